// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the main-memory port arbiter: memory word size,
// FSM state encoding, arbitration mode selectors and an index-width helper.
`ifndef MAIN_MEMORY_READ_SIZE
`define MAIN_MEMORY_READ_SIZE 32
`endif

package mem_port_arbiter_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    // Width of a port index; never zero so a single-port build still has a field.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_picker.sv
// Combinational request picker: fixed priority (lowest index) or a search
// starting at a rotating pointer that wraps from NUM_PORTS-1 back to 0.
module rr_priority_picker
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int IW        = idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IW-1:0]        start,
    input  logic                 mode,
    output logic [NUM_PORTS-1:0] winner_oh,
    output logic [IW-1:0]        winner_idx,
    output logic                 found
);

    int            base;
    int            p;
    logic [IW-1:0] pi;

    always_comb begin
        winner_oh  = '0;
        winner_idx = '0;
        found      = 1'b0;
        base       = mode ? int'(start) : 0;
        p          = 0;
        pi         = '0;
        if (base >= NUM_PORTS) base = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            p = base + k;
            if (p >= NUM_PORTS) p = p - NUM_PORTS;
            pi = IW'(p);
            if (!found && req[pi]) begin
                found         = 1'b1;
                winner_oh[pi] = 1'b1;
                winner_idx    = pi;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port among NUM_PORTS requesters: registers the winning
// request, holds it until mem_ready, then pulses ack to that requester only.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = `MAIN_MEMORY_READ_SIZE,
    parameter int ARB_MODE   = ARB_FIXED
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            req,
    input  logic [NUM_PORTS-1:0]            we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata,
    output logic [NUM_PORTS-1:0]            ack,
    output logic [DATA_WIDTH-1:0]           rdata,
    output logic                            busy,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    output logic                            mem_re,
    output logic                            mem_wr,
    input  logic [DATA_WIDTH-1:0]           mem_rdata,
    input  logic                            mem_ready
);

    localparam int IW = idx_width(NUM_PORTS);

    arb_state_e            state_q, state_d;
    logic [IW-1:0]         grant_id, rr_ptr, win_idx;
    logic [NUM_PORTS-1:0]  win_oh;
    logic                  win_found;
    logic                  win_we;
    logic [ADDR_WIDTH-1:0] addr_a  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] wdata_a [NUM_PORTS];

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
        assign addr_a[i]  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_a[i] = wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_priority_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IW        (IW)
    ) u_picker (
        .req        (req),
        .start      (rr_ptr),
        .mode       (ARB_MODE == ARB_RR),
        .winner_oh  (win_oh),
        .winner_idx (win_idx),
        .found      (win_found)
    );

    assign win_we = |(we & win_oh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (win_found) state_d = ST_BUSY;
            ST_BUSY: if (mem_ready) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request capture and completion; mem_ready is meaningful only while BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_re    <= 1'b0;
            mem_wr    <= 1'b0;
            grant_id  <= '0;
            rr_ptr    <= '0;
            rdata     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_found) begin
                        mem_addr  <= addr_a[win_idx];
                        mem_wdata <= wdata_a[win_idx];
                        mem_re    <= ~win_we;
                        mem_wr    <= win_we;
                        grant_id  <= win_idx;
                        if (ARB_MODE == ARB_RR)
                            rr_ptr <= (win_idx == IW'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (mem_ready) begin
                        if (mem_re) rdata <= mem_rdata;
                        mem_re <= 1'b0;
                        mem_wr <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ack  = (state_q == ST_RESP) ? (NUM_PORTS'(1) << grant_id) : '0;
    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a fixed-priority and a round-robin arbiter share stimulus and
// a simple memory model that raises mem_ready mem_delay cycles into an access.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0;
    logic [1:0]  we = '0;
    logic [63:0] addr = '0;
    logic [63:0] wdata = '0;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    logic [1:0]  f_ack, r_ack;
    logic [31:0] f_rdata, r_rdata, f_mem_addr, r_mem_addr, f_mem_wdata, r_mem_wdata;
    logic        f_busy, r_busy, f_mem_re, r_mem_re, f_mem_wr, r_mem_wr;

    int mem_delay = 1;
    int mem_cnt = 0;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(0)) dut_fix (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(f_ack), .rdata(f_rdata), .busy(f_busy), .mem_addr(f_mem_addr),
        .mem_wdata(f_mem_wdata), .mem_re(f_mem_re), .mem_wr(f_mem_wr),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    mem_port_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(r_ack), .rdata(r_rdata), .busy(r_busy), .mem_addr(r_mem_addr),
        .mem_wdata(r_mem_wdata), .mem_re(r_mem_re), .mem_wr(r_mem_wr),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    // Both arbiters share FSM timing, so the memory model follows the fixed one.
    always @(posedge clk) begin
        #1;
        if (f_mem_re || f_mem_wr) begin
            mem_ready = (mem_cnt == mem_delay);
            mem_cnt++;
        end else begin
            mem_ready = 1'b0;
            mem_cnt = 0;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; req = '0; we = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_ack(input bit use_rr, output logic [1:0] a, output int n);
        a = 2'b00; n = 0;
        for (int i = 0; i < 60 && a == 2'b00; i++) begin
            @(negedge clk);
            n++;
            a = use_rr ? r_ack : f_ack;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; we = '0;
        @(negedge clk);
        n_tests++; if (f_ack !== 2'b00) begin n_fail++; $display("FAIL reset_ack got %b want 00", f_ack); end
        n_tests++; if (f_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", f_busy); end
        n_tests++; if ({f_mem_re, f_mem_wr} !== 2'b00) begin n_fail++; $display("FAIL reset_re_wr got %b want 00", {f_mem_re, f_mem_wr}); end
        n_tests++; if (f_mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", f_mem_addr); end
        n_tests++; if (f_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", f_rdata); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fixed_priority();
        logic [1:0] a; int n;
        do_reset();
        mem_delay = 1; mem_rdata = 32'hA5A5_0001;
        addr = {32'h0000_0200, 32'h0000_0100}; we = 2'b00; req = 2'b11;
        @(negedge clk);
        n_tests++; if (f_mem_addr !== 32'h100) begin n_fail++; $display("FAIL fix_first_addr got %h want 100", f_mem_addr); end
        n_tests++; if ({f_mem_re, f_mem_wr, f_busy} !== 3'b101) begin n_fail++; $display("FAIL fix_first_re_wr_busy got %b want 101", {f_mem_re, f_mem_wr, f_busy}); end
        wait_ack(1'b0, a, n);
        n_tests++; if (a !== 2'b01) begin n_fail++; $display("FAIL fix_first_ack got %b want 01", a); end
        n_tests++; if (n !== 2) begin n_fail++; $display("FAIL fix_ack_latency got %0d want 2", n); end
        n_tests++; if (f_rdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL fix_first_rdata got %h want a5a50001", f_rdata); end
        req = 2'b10; mem_rdata = 32'hA5A5_0002;
        wait_ack(1'b0, a, n);
        req = 2'b00;
        n_tests++; if (a !== 2'b10) begin n_fail++; $display("FAIL fix_second_ack got %b want 10", a); end
        n_tests++; if (f_mem_addr !== 32'h200) begin n_fail++; $display("FAIL fix_second_addr got %h want 200", f_mem_addr); end
        n_tests++; if (f_rdata !== 32'hA5A5_0002) begin n_fail++; $display("FAIL fix_second_rdata got %h want a5a50002", f_rdata); end
    endtask

    task automatic test_round_robin();
        logic [1:0] a, exp; int n;
        do_reset();
        mem_delay = 0; addr = {32'h0000_0220, 32'h0000_0110}; we = 2'b00; req = 2'b11;
        for (int i = 0; i < 6; i++) begin
            wait_ack(1'b1, a, n);
            if (i == 5) req = 2'b00;
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            n_tests++; if (a !== exp) begin n_fail++; $display("FAIL rr_order[%0d] got %b want %b", i, a, exp); end
            n_tests++; if (f_ack !== 2'b01) begin n_fail++; $display("FAIL fix_starve[%0d] got %b want 01", i, f_ack); end
        end
        @(negedge clk);
    endtask

    task automatic test_write();
        logic [1:0] a; int n;
        do_reset();
        mem_delay = 1; mem_rdata = 32'h1111_2222;
        addr[31:0] = 32'h80; we = 2'b00; req = 2'b01;
        wait_ack(1'b0, a, n);
        req = 2'b00;
        n_tests++; if (f_rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL wr_prior_read got %h want 11112222", f_rdata); end
        @(negedge clk);
        addr[63:32] = 32'h40; wdata[63:32] = 32'hDEAD_BEEF; we = 2'b10; req = 2'b10;
        mem_rdata = 32'h9999_9999;
        @(negedge clk);
        n_tests++; if ({f_mem_re, f_mem_wr} !== 2'b01) begin n_fail++; $display("FAIL wr_re_wr got %b want 01", {f_mem_re, f_mem_wr}); end
        n_tests++; if (f_mem_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_wdata got %h want deadbeef", f_mem_wdata); end
        n_tests++; if (f_mem_addr !== 32'h40) begin n_fail++; $display("FAIL wr_addr got %h want 40", f_mem_addr); end
        wait_ack(1'b0, a, n);
        req = 2'b00; we = 2'b00;
        n_tests++; if (a !== 2'b10) begin n_fail++; $display("FAIL wr_ack got %b want 10", a); end
        n_tests++; if (f_rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL wr_rdata_kept got %h want 11112222", f_rdata); end
    endtask

    task automatic test_long_wait();
        logic [1:0] a_after; bit stable, early, prev, done;
        do_reset();
        mem_delay = 10; mem_rdata = 32'h1234_5678;
        addr[31:0] = 32'h300; we = 2'b00; req = 2'b01;
        @(negedge clk);
        addr[31:0] = 32'h3FC;
        stable = 1'b1; early = 1'b0; prev = 1'b0; done = 1'b0; a_after = 2'b00;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (prev) begin
                a_after = f_ack; done = 1'b1;
            end else begin
                if (f_ack !== 2'b00) early = 1'b1;
                if (f_mem_addr !== 32'h300 || f_mem_re !== 1'b1) stable = 1'b0;
            end
            prev = mem_ready;
        end
        req = 2'b00;
        n_tests++; if (stable !== 1'b1) begin n_fail++; $display("FAIL wait_addr_stable got %b want 1", stable); end
        n_tests++; if (early !== 1'b0) begin n_fail++; $display("FAIL wait_early_ack got %b want 0", early); end
        n_tests++; if (a_after !== 2'b01) begin n_fail++; $display("FAIL wait_ack_after_ready got %b want 01", a_after); end
        n_tests++; if (f_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL wait_rdata got %h want 12345678", f_rdata); end
        @(negedge clk);
    endtask

    task automatic test_reset_busy();
        bit saw;
        do_reset();
        mem_delay = 100; addr[31:0] = 32'h500; we = 2'b00; req = 2'b01;
        @(negedge clk);
        @(negedge clk);
        n_tests++; if (f_busy !== 1'b1) begin n_fail++; $display("FAIL rstbusy_pre got %b want 1", f_busy); end
        rst_n = 1'b0; req = 2'b00;
        #1;
        n_tests++; if ({f_mem_re, f_mem_wr} !== 2'b00) begin n_fail++; $display("FAIL rstbusy_re_wr got %b want 00", {f_mem_re, f_mem_wr}); end
        n_tests++; if ({f_busy, r_busy} !== 2'b00) begin n_fail++; $display("FAIL rstbusy_busy got %b want 00", {f_busy, r_busy}); end
        n_tests++; if (f_ack !== 2'b00) begin n_fail++; $display("FAIL rstbusy_ack got %b want 00", f_ack); end
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (f_ack !== 2'b00 || r_ack !== 2'b00) saw = 1'b1;
        end
        n_tests++; if (saw !== 1'b0) begin n_fail++; $display("FAIL rstbusy_no_ack got %b want 0", saw); end
        mem_delay = 1;
    endtask

    task automatic test_req_drop();
        logic [1:0] a; int n;
        do_reset();
        mem_delay = 3; addr = {32'h0000_0600, 32'h0000_0700}; we = 2'b00; req = 2'b11;
        @(negedge clk);
        req = 2'b10;
        wait_ack(1'b0, a, n);
        n_tests++; if (a !== 2'b01) begin n_fail++; $display("FAIL drop_ack0 got %b want 01", a); end
        wait_ack(1'b0, a, n);
        req = 2'b00;
        n_tests++; if (a !== 2'b10) begin n_fail++; $display("FAIL drop_next_ack got %b want 10", a); end
        n_tests++; if (f_mem_addr !== 32'h600) begin n_fail++; $display("FAIL drop_next_addr got %h want 600", f_mem_addr); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_write();
        test_long_wait();
        test_reset_busy();
        test_req_drop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
